// File: rtl/rconst_seq.sv
// Keccak iota round-constant generator: an 8-bit LFSR advanced 7 steps per round,
// streaming one W-bit constant per round to the permutation over valid/ready.
module rconst_seq #(
    parameter int W  = 64,
    parameter int NR = 12 + 2 * $clog2(W)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         rc_ready,
    output logic         rc_valid,
    output logic [W-1:0] rc,
    output logic [4:0]   round_idx,
    output logic         rc_last,
    output logic         done,
    output logic         dbg_state
);

    localparam int          L          = $clog2(W);
    localparam logic [4:0]  LAST_ROUND = 5'(NR - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [7:0]   lfsr_q, lfsr_d;
    logic [W-1:0] rc_q, rc_d;
    logic [4:0]   round_q, round_d;
    logic         valid_q, valid_d;
    logic         done_q, done_d;

    logic [7:0]   seed;
    logic [7:0]   lfsr_s7;
    logic [W-1:0] rc_next;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], 1'b0} ^ (s[7] ? 8'h71 : 8'h00);
    endfunction

    // lfsr_q holds the start state of the round after the one being presented,
    // so a single 7-step unroll serves both a fresh start and an acceptance.
    always_comb begin
        logic [7:0] s;
        seed    = start ? 8'h01 : lfsr_q;
        s       = seed;
        rc_next = '0;
        for (int j = 0; j <= L; j++) begin
            rc_next = rc_next | (W'(s[0]) << ((1 << j) - 1));
            s       = lfsr_step(s);
        end
        for (int j = L + 1; j < 7; j++) begin
            s = lfsr_step(s);
        end
        lfsr_s7 = s;
    end

    // Handshake: a constant transfers on a cycle where rc_valid && rc_ready;
    // rc/round_idx stay stable while rc_valid=1 and rc_ready=0. start overrides.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        rc_d    = rc_q;
        round_d = round_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        if (start) begin
            state_d = RUN;
            lfsr_d  = lfsr_s7;
            rc_d    = rc_next;
            round_d = 5'd0;
            valid_d = 1'b1;
        end else if (state_q == RUN && rc_ready) begin
            if (round_q == LAST_ROUND) begin
                state_d = IDLE;
                lfsr_d  = 8'h01;
                rc_d    = '0;
                round_d = 5'd0;
                valid_d = 1'b0;
                done_d  = 1'b1;
            end else begin
                lfsr_d  = lfsr_s7;
                rc_d    = rc_next;
                round_d = round_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            lfsr_q  <= 8'h01;
            rc_q    <= '0;
            round_q <= 5'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            rc_q    <= rc_d;
            round_q <= round_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign rc_valid  = valid_q;
    assign rc        = rc_q;
    assign round_idx = round_q;
    assign rc_last   = valid_q && (round_q == LAST_ROUND);
    assign done      = done_q;
    assign dbg_state = (state_q == RUN);

endmodule

// File: tb/tb_rconst_seq.sv
// Bench for rconst_seq: three widths share one stimulus stream; a cycle model
// predicts every output and a monitor pops and compares each cycle.
module tb_rconst_seq;

    logic clk = 1'b0;
    logic reset_n;
    logic start;
    logic rc_ready;

    always #5 clk = ~clk;

    logic        vld64, vld32, vld8;
    logic [63:0] rc64;
    logic [31:0] rc32;
    logic [7:0]  rc8;
    logic [4:0]  ridx64, ridx32, ridx8;
    logic        lst64, lst32, lst8;
    logic        dn64, dn32, dn8;
    logic        dbg64, dbg32, dbg8;

    rconst_seq #(.W(64), .NR(24)) u_w64 (
        .clk(clk), .reset_n(reset_n), .start(start), .rc_ready(rc_ready),
        .rc_valid(vld64), .rc(rc64), .round_idx(ridx64), .rc_last(lst64),
        .done(dn64), .dbg_state(dbg64)
    );

    rconst_seq #(.W(32), .NR(22)) u_w32 (
        .clk(clk), .reset_n(reset_n), .start(start), .rc_ready(rc_ready),
        .rc_valid(vld32), .rc(rc32), .round_idx(ridx32), .rc_last(lst32),
        .done(dn32), .dbg_state(dbg32)
    );

    rconst_seq #(.W(8), .NR(18)) u_w8 (
        .clk(clk), .reset_n(reset_n), .start(start), .rc_ready(rc_ready),
        .rc_valid(vld8), .rc(rc8), .round_idx(ridx8), .rc_last(lst8),
        .done(dn8), .dbg_state(dbg8)
    );

    typedef struct packed {
        logic        valid;
        logic [4:0]  round;
        logic [63:0] rc;
        logic        last;
        logic        done;
    } exp_t;
    typedef exp_t [2:0] exp3_t;

    exp3_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    bit    seq_bits [0:255];

    function automatic int nr_of(input int i);
        return (i == 0) ? 24 : (i == 1) ? 22 : 18;
    endfunction

    function automatic int w_of(input int i);
        return (i == 0) ? 64 : (i == 1) ? 32 : 8;
    endfunction

    // Constant for round r: bit 2^j-1 is the LFSR output bit at time 7r+j.
    function automatic logic [63:0] ref_rc(input int r, input int w);
        logic [63:0] res;
        int          l;
        res = '0;
        l   = $clog2(w);
        for (int j = 0; j <= l; j++) begin
            if (seq_bits[7 * r + j]) res = res | (64'd1 << ((1 << j) - 1));
        end
        return res;
    endfunction

    function automatic bit known_rc(input int i, input int r, output logic [63:0] v);
        v = '0;
        case (i)
            0: case (r)
                   0:  begin v = 64'h0000000000000001; return 1'b1; end
                   1:  begin v = 64'h0000000000008082; return 1'b1; end
                   2:  begin v = 64'h800000000000808A; return 1'b1; end
                   4:  begin v = 64'h000000000000808B; return 1'b1; end
                   23: begin v = 64'h8000000080008008; return 1'b1; end
                   default: return 1'b0;
               endcase
            1: case (r)
                   1: begin v = 64'h0000000000008082; return 1'b1; end
                   3: begin v = 64'h0000000080008000; return 1'b1; end
                   default: return 1'b0;
               endcase
            default: case (r)
                   1: begin v = 64'h0000000000000082; return 1'b1; end
                   2: begin v = 64'h000000000000008A; return 1'b1; end
                   default: return 1'b0;
               endcase
        endcase
    endfunction

    task automatic check(input string name, input int inst,
                         input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s inst%0d t=%0t got %h exp %h", name, inst, $time, got, exp);
        end
    endtask

    // Reference model: tracks per-instance sequence position from the inputs only.
    initial begin
        logic [7:0] s;
        bit         m_valid [3];
        int         m_round [3];
        bit         m_done  [3];
        exp3_t      e;
        s = 8'h01;
        for (int t = 0; t < 256; t++) begin
            seq_bits[t] = s[0];
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h71 : 8'h00);
        end
        for (int i = 0; i < 3; i++) begin
            m_valid[i] = 1'b0;
            m_round[i] = 0;
            m_done[i]  = 1'b0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                m_done[i] = 1'b0;
                if (!reset_n) begin
                    m_valid[i] = 1'b0;
                    m_round[i] = 0;
                end else if (start) begin
                    m_valid[i] = 1'b1;
                    m_round[i] = 0;
                end else if (m_valid[i] && rc_ready) begin
                    if (m_round[i] == nr_of(i) - 1) begin
                        m_valid[i] = 1'b0;
                        m_done[i]  = 1'b1;
                    end else begin
                        m_round[i] = m_round[i] + 1;
                    end
                end
                e[i].valid = m_valid[i];
                e[i].round = 5'(m_round[i]);
                e[i].rc    = m_valid[i] ? ref_rc(m_round[i], w_of(i)) : 64'd0;
                e[i].last  = m_valid[i] && (m_round[i] == nr_of(i) - 1);
                e[i].done  = m_done[i];
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: outputs are registered, so the falling edge sees settled values.
    initial begin
        exp3_t       e;
        logic [63:0] g_rc  [3];
        logic        g_vld [3];
        logic [4:0]  g_rnd [3];
        logic        g_lst [3];
        logic        g_dn  [3];
        logic        g_dbg [3];
        logic [63:0] lit;
        forever begin
            @(negedge clk);
            g_rc[0] = rc64;            g_rc[1] = {32'd0, rc32};  g_rc[2] = {56'd0, rc8};
            g_vld[0] = vld64;          g_vld[1] = vld32;         g_vld[2] = vld8;
            g_rnd[0] = ridx64;         g_rnd[1] = ridx32;        g_rnd[2] = ridx8;
            g_lst[0] = lst64;          g_lst[1] = lst32;         g_lst[2] = lst8;
            g_dn[0]  = dn64;           g_dn[1]  = dn32;          g_dn[2]  = dn8;
            g_dbg[0] = dbg64;          g_dbg[1] = dbg32;         g_dbg[2] = dbg8;
            if (exp_q.size() == 0) begin
                check("queue_underflow", 0, 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                for (int i = 0; i < 3; i++) begin
                    check("rc_valid", i, 64'(g_vld[i]), 64'(e[i].valid));
                    check("rc", i, g_rc[i], e[i].rc);
                    check("rc_last", i, 64'(g_lst[i]), 64'(e[i].last));
                    check("done", i, 64'(g_dn[i]), 64'(e[i].done));
                    check("dbg_state", i, 64'(g_dbg[i]), 64'(e[i].valid));
                    if (e[i].valid) begin
                        check("round_idx", i, 64'(g_rnd[i]), 64'(e[i].round));
                        if (known_rc(i, int'(e[i].round), lit))
                            check("known_rc", i, g_rc[i], lit);
                    end
                end
            end
        end
    end

    task automatic cyc(input bit s, input bit r);
        @(negedge clk);
        start    = s;
        rc_ready = r;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_valid"}, 0, 64'(vld64), 64'd0);
        check({name, "_rc"}, 0, rc64, 64'd0);
        check({name, "_round"}, 0, 64'(ridx64), 64'd0);
        check({name, "_valid"}, 1, 64'(vld32), 64'd0);
        check({name, "_rc"}, 1, 64'(rc32), 64'd0);
        check({name, "_round"}, 1, 64'(ridx32), 64'd0);
        check({name, "_valid"}, 2, 64'(vld8), 64'd0);
        check({name, "_rc"}, 2, 64'(rc8), 64'd0);
        check({name, "_round"}, 2, 64'(ridx8), 64'd0);
    endtask

    initial begin
        bit bp [6];
        reset_n  = 1'b0;
        start    = 1'b0;
        rc_ready = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;

        // Full sequence with rc_ready held high.
        cyc(1'b1, 1'b0);
        repeat (30) cyc(1'b0, 1'b1);

        // Backpressure on rounds 4 and 5.
        bp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        cyc(1'b1, 1'b0);
        repeat (4) cyc(1'b0, 1'b1);
        for (int k = 0; k < 6; k++) cyc(1'b0, bp[k]);
        repeat (25) cyc(1'b0, 1'b1);

        // Restart at round 7, then start coincident with the final acceptance.
        cyc(1'b1, 1'b0);
        repeat (7) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        repeat (23) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        repeat (3) cyc(1'b0, 1'b1);

        // Reset at round 10, then a clean sequence afterwards.
        cyc(1'b1, 1'b0);
        repeat (10) cyc(1'b0, 1'b1);
        @(negedge clk);
        #2;
        reset_n  = 1'b0;
        start    = 1'b0;
        rc_ready = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        cyc(1'b1, 1'b0);
        repeat (26) cyc(1'b0, 1'b1);

        // Random backpressure with occasional restarts.
        for (int k = 0; k < 400; k++) begin
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0);
        end
        repeat (3) cyc(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rconst_seq.md
Name: rconst_seq

Overview:
- Sequential, parametrised Keccak round-constant generator. It produces the iota-step constant for every round of Keccak-f[25*W] from an internal 8-bit LFSR rather than a one-hot lookup.
- Constants are streamed to the permutation datapath one round at a time over a valid/ready handshake, so the core no longer needs a one-hot round register.
- Supports lane widths 8/16/32/64 and a reduced round count.

Parameters:
- W, 64: lane width in bits. Legal values: 8, 16, 32, 64. L = log2(W).
- NR, 12+2*L: number of rounds emitted per sequence. Legal range: 1..12+2*L. Round indices always start at 0.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; begins (or restarts) a constant sequence
- rc_ready  in  1  consumer accepts the current constant this cycle
- rc_valid  out  1  rc / round_idx hold a valid constant
- rc  out  W  round constant for round round_idx (bits 2^j-1, j=0..L; all other bits 0)
- round_idx  out  5  index of the current round, 0..NR-1
- rc_last  out  1  current constant belongs to round NR-1 (qualified by rc_valid)
- done  out  1  single-cycle pulse, one cycle after the last constant is accepted

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - rc_valid=0, rc=0, round_idx=0, rc_last=0, done=0.
  - LFSR=8'h01. State=IDLE.
- LFSR: 8-bit state S, polynomial x^8+x^6+x^5+x^4+1.
  - One step: S' = {S[6:0],1'b0} XOR (S[7] ? 8'h71 : 8'h00).
  - rc(t) = S[0] after t steps from 8'h01.
- Per-round computation, done combinationally with 7 unrolled steps:
  - From the state at t=7*ir, bit j of the constant is S_j[0], where S_j is the state after j steps, j=0..L.
  - rc[2^j-1] = S_j[0].
  - The next-round state is S_7, even when W<64.
- States:
  - IDLE: rc_valid=0. On start: LFSR<=8'h01, round_idx<=0, rc<=constant for round 0, rc_valid<=1, go to RUN.
  - RUN: rc_valid=1, rc stable while rc_ready=0.
    - On rc_ready with round_idx<NR-1: advance the LFSR by 7 steps, round_idx+1, load the next rc. No bubble; a new constant is presented the next cycle.
    - On rc_ready with round_idx==NR-1: rc_valid<=0, rc<=0, done<=1 for one cycle, go to IDLE.
- rc_last = rc_valid && (round_idx==NR-1), decoded from registered state.
- Output latency: constant registered; one cycle from start (or acceptance) to the new rc.
- start while in RUN: the sequence restarts at round 0 next cycle. start has priority over a simultaneous rc_ready, and no done pulse is generated.
- start in the same cycle as the final acceptance: the restart wins and done is suppressed.
- rc_ready while rc_valid=0: ignored.
- reset_n asserted mid-sequence: immediately returns to the reset values; no done pulse.
- round_idx never exceeds NR-1; no wrap-around inside a sequence.

Test Plan:
- W=64, NR=24. Pulse start, then hold rc_ready=1.
  -> round 0 rc=64'h0000000000000001, round 1 64'h0000000000008082, round 2 64'h800000000000808A, round 23 64'h8000000080008008.
  -> rc_last=1 only on round 23; done pulses exactly once, one cycle after the round-23 acceptance; 24 accepted constants total.
- W=32, NR=22.
  -> round 1 rc=32'h00008082, round 3 32'h80008000; sequence ends at round_idx=21 with done.
- W=8, NR=18.
  -> round 1 rc=8'h82, round 2 8'h8A; 18 constants, then done.
- Backpressure: toggle rc_ready with pattern 1,0,0,1 during round 4 (W=64).
  -> rc holds 64'h000000000000808B and round_idx holds 4 for the stalled cycles; no round skipped.
- Restart: assert start at round 7.
  -> next cycle round_idx=0, rc=64'h1; no done pulse.
  -> start coincident with the final acceptance gives round 0 next cycle and no done.
- Reset: drop reset_n at round 10.
  -> rc_valid=0, rc=0, round_idx=0 immediately.
  -> after release, start gives round 0 rc=64'h1.
